// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter: FSM state
// encoding, default timing constants for a 7 MHz clock enable, keyboard
// command bytes and the frame parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5
    } state_t;

    // Timing in ce ticks at 7 MHz.
    localparam int unsigned INHIBIT_DEF = 800;     // >= 100 us clock inhibit
    localparam int unsigned TIMEOUT_DEF = 112000;  // 16 ms frame watchdog
    localparam int unsigned TW_DEF      = 17;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 line: 2-flop synchroniser on clock, then a
// 4-sample stability filter clocked by ce, plus falling-edge detect.
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset (line reads as idle-high)
//   ce     clock enable for the filter
//   pin    raw pin level
//   level  filtered line level
//   fall   high for one ce period after the filtered level drops 1->0
module ps2_line_filter (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [1:0] sync;
    logic [3:0] hist;
    logic [3:0] hist_n;

    assign hist_n = {hist[2:0], sync[1]};

    // Reset to the idle-high level so releasing reset never fakes an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pin};
        end
    end

    // The level only changes once four consecutive samples agree.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist  <= 4'hF;
            level <= 1'b1;
            fall  <= 1'b0;
        end else if (ce) begin
            hist <= hist_n;
            if (hist_n == 4'h0) begin
                level <= 1'b0;
            end else if (hist_n == 4'hF) begin
                level <= 1'b1;
            end
            fall <= level && (hist_n == 4'h0);
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Inhibits the clock, issues the start bit,
// then shifts out data LSB first, odd parity and stop on device clock falls,
// and checks the device acknowledge. A watchdog aborts stalled frames.
// Ports:
//   clock, reset   system clock, asynchronous active-low reset
//   ce             clock enable (ne7M0)
//   ps2Ck, ps2DQ   raw keyboard clock / data pin levels
//   ckOe, dqOe     1 = pull keyboard clock / data low (open-drain)
//   send, d        one-ce request and command byte (accepted in IDLE only)
//   busy           frame in progress
//   done, error    one-ce result pulses (acknowledged / timeout or NACK)
//
// state    | meaning
// IDLE     | lines released, waiting for send
// INHIBIT  | clock held low before the start bit
// RELEASE  | start bit driven, clock released next tick
// SHIFT    | drive data, parity, stop on each device clock fall
// ACK      | sample the device acknowledge on the next clock fall
// WAITIDLE | wait for both lines high, then report the result
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT = INHIBIT_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TW      = TW_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2DQ,
    output logic       ckOe,
    output logic       dqOe,
    input  logic       send,
    input  logic [7:0] d,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_SAT  = TW'(TIMEOUT);

    state_t        state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic [8:0]    shreg, shreg_n;
    logic          ck_oe_q, ck_n;
    logic          dq_oe_q, dq_n;
    logic          nack, nack_n;
    logic          done_q, done_n;
    logic          error_q, error_n;

    logic ck_level, ck_fall;
    logic dq_level, dq_edge_unused;

    ps2_line_filter u_ck_filter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .pin   (ps2Ck),
        .level (ck_level),
        .fall  (ck_fall)
    );

    ps2_line_filter u_dq_filter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .pin   (ps2DQ),
        .level (dq_level),
        .fall  (dq_edge_unused)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            ck_oe_q <= 1'b0;
            dq_oe_q <= 1'b0;
            nack    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (ce) begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            ck_oe_q <= ck_n;
            dq_oe_q <= dq_n;
            nack    <= nack_n;
            done_q  <= done_n;
            error_q <= error_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        ck_n    = ck_oe_q;
        dq_n    = dq_oe_q;
        nack_n  = nack;
        done_n  = 1'b0;
        error_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (send) begin
                    shreg_n = {odd_parity(d), d};
                    ck_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == INHIBIT_LAST) begin
                    dq_n    = 1'b1;
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ck_n    = 1'b0;
                cnt_n   = '0;
                idx_n   = '0;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Shifting in ones means the tenth bit out is the stop bit.
                if (ck_fall) begin
                    dq_n    = ~shreg[0];
                    shreg_n = {1'b1, shreg[8:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 4'd9) begin
                        state_n = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (ck_fall) begin
                    nack_n  = dq_level;
                    state_n = ST_WAITIDLE;
                end
            end
            ST_WAITIDLE: begin
                if (ck_level && dq_level) begin
                    done_n  = ~nack;
                    error_n = nack;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Watchdog runs from clock release; expiry overrides any edge seen
        // in the same tick.
        if (state == ST_SHIFT || state == ST_ACK || state == ST_WAITIDLE) begin
            if (cnt != TIMEOUT_SAT) begin
                cnt_n = cnt + 1'b1;
            end
            if (cnt == TIMEOUT_LAST) begin
                ck_n    = 1'b0;
                dq_n    = 1'b0;
                done_n  = 1'b0;
                error_n = 1'b1;
                state_n = ST_IDLE;
            end
        end
    end

    assign ckOe  = ck_oe_q;
    assign dqOe  = dq_oe_q;
    assign busy  = (state != ST_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 40;
    localparam int TMO = 1500;
    localparam int H   = 16;   // device half-period in ce ticks

    localparam int SIG_CK   = 0;
    localparam int SIG_DQ   = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_ERR  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] d     = 8'h00;
    logic [1:0] div   = 2'd0;
    logic       ce;
    logic       ps2Ck, ps2DQ;
    logic       ckOe, dqOe, busy, done, error;
    logic       dev_ck_low = 1'b0;
    logic       dev_dq_low = 1'b0;

    int          total = 0;
    int          bad   = 0;
    int unsigned ticks = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    logic [10:0] exp_frames[$];
    logic [1:0]  exp_res[$];

    ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .TW(17)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .ps2Ck (ps2Ck),
        .ps2DQ (ps2DQ),
        .ckOe  (ckOe),
        .dqOe  (dqOe),
        .send  (send),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) div <= div + 2'd1;
    assign ce = (div == 2'd0);
    always @(posedge clock) if (ce) ticks <= ticks + 1;

    // Open-drain wiring with pull-ups.
    assign ps2Ck = ~(ckOe | dev_ck_low);
    assign ps2DQ = ~(dqOe | dev_dq_low);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: every done/error rising edge pops one expected result.
    logic done_d = 1'b0;
    logic err_d  = 1'b0;
    always @(negedge clock) begin
        if ((done && !done_d) || (error && !err_d)) begin
            if (done && !done_d) done_cnt++;
            if (error && !err_d) err_cnt++;
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result: got pulse {error,done}=%b expected none", {error, done});
            end else begin
                check("result", {30'd0, error, done}, {30'd0, exp_res.pop_front()});
            end
        end
        done_d = done;
        err_d  = error;
    end

    function automatic logic sig(input int which);
        case (which)
            SIG_CK:   return ckOe;
            SIG_DQ:   return dqOe;
            SIG_BUSY: return busy;
            default:  return error;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic val, input int limit,
                            input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (sig(which) === val) begin
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: got no change to %b within %0d clocks", name, val, limit);
    endtask

    task automatic wait_ticks(input int n);
        repeat (4 * n) @(negedge clock);
    endtask

    task automatic do_send(input logic [7:0] b);
        @(negedge clock);
        while (!ce) @(negedge clock);
        d    = b;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        d    = ~b;
    endtask

    // Device model. mode: 0 ack, 1 nack, 2 silent, 3 reset at bit 4.
    task automatic dev_frame(input int mode, input logic [7:0] b);
        logic [10:0] cap;
        bit          ok;
        int unsigned t0;
        cap = '0;
        wait_for(SIG_CK, 1'b1, 2000, "ckoe_assert", ok);
        if (!ok) return;
        t0 = ticks;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        wait_for(SIG_DQ, 1'b1, (INH + 10) * 4, "start_bit", ok);
        if (!ok) return;
        check("inhibit_ticks", ticks - t0, INH);
        wait_for(SIG_CK, 1'b0, 40, "ck_release", ok);
        if (!ok) return;
        t0 = ticks;
        cap[0] = ps2DQ;
        if (mode == 2) begin
            check("start_level", {31'd0, cap[0]}, 32'd0);
            wait_for(SIG_ERR, 1'b1, (TMO + 10) * 4, "timeout_error", ok);
            if (!ok) return;
            check("timeout_ticks", ticks - t0, TMO);
            check("timeout_ckoe", {31'd0, ckOe}, 32'd0);
            check("timeout_dqoe", {31'd0, dqOe}, 32'd0);
            check("timeout_busy", {31'd0, busy}, 32'd0);
            return;
        end
        for (int i = 1; i <= 10; i++) begin
            wait_ticks(H);
            dev_ck_low = 1'b1;
            wait_ticks(H);
            cap[i] = ps2DQ;
            dev_ck_low = 1'b0;
            if (mode == 3 && i == 5) begin
                check("dq_before_reset", {31'd0, dqOe}, {31'd0, ~b[4]});
                reset = 1'b0;
                #1;
                check("reset_ckoe", {31'd0, ckOe}, 32'd0);
                check("reset_dqoe", {31'd0, dqOe}, 32'd0);
                check("reset_busy", {31'd0, busy}, 32'd0);
                wait_ticks(3);
                reset = 1'b1;
            end
        end
        if (mode == 3) begin
            wait_ticks(H);
            dev_ck_low = 1'b1;
            wait_ticks(H);
            dev_ck_low = 1'b0;
            return;
        end
        wait_ticks(H / 2);
        if (mode == 0) dev_dq_low = 1'b1;
        wait_ticks(H / 2);
        dev_ck_low = 1'b1;
        wait_ticks(H);
        dev_ck_low = 1'b0;
        wait_ticks(H / 2);
        dev_dq_low = 1'b0;
        if (exp_frames.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame: got %b expected none", cap);
        end else begin
            check("frame", {21'd0, cap}, {21'd0, exp_frames.pop_front()});
        end
    endtask

    // Expected frame on the wire: stop, parity, data MSB..LSB, start.
    task automatic run(input logic [7:0] b, input logic par, input int mode);
        bit ok;
        if (mode == 0 || mode == 1) exp_frames.push_back({1'b1, par, b, 1'b0});
        if (mode == 0) exp_res.push_back(2'b01);
        if (mode == 1 || mode == 2) exp_res.push_back(2'b10);
        fork
            do_send(b);
            dev_frame(mode, b);
        join
        wait_for(SIG_BUSY, 1'b0, 4000, "busy_fall", ok);
        wait_ticks(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int dc, ec;
        bit ok;
        wait_ticks(3);
        check("rst_ckoe",  {31'd0, ckOe},  32'd0);
        check("rst_dqoe",  {31'd0, dqOe},  32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b1;
        wait_ticks(8);

        // LED command: bits 1,0,1,1,0,1,1,1 parity 1
        run(CMD_SET_LEDS, 1'b1, 0);
        run(8'h07, 1'b0, 0);
        run(8'h00, 1'b1, 0);

        // silent device -> watchdog
        run(CMD_RESET, 1'b1, 2);

        // device leaves data high on the 11th fall
        dc = done_cnt;
        run(CMD_RESET, 1'b1, 1);
        check("nack_no_done", done_cnt, dc);

        // reset mid-frame, then a fresh command
        dc = done_cnt;
        ec = err_cnt;
        run(CMD_SET_LEDS, 1'b1, 3);
        wait_ticks(20);
        check("abort_no_done",  done_cnt, dc);
        check("abort_no_error", err_cnt, ec);
        check("abort_ckoe", {31'd0, ckOe}, 32'd0);
        run(CMD_ENABLE, 1'b0, 0);

        // send while busy is ignored
        dc = done_cnt;
        exp_frames.push_back({1'b1, 1'b1, CMD_SET_LEDS, 1'b0});
        exp_res.push_back(2'b01);
        fork
            do_send(CMD_SET_LEDS);
            dev_frame(0, CMD_SET_LEDS);
            begin
                wait_ticks(10);
                do_send(8'h55);
                wait_ticks(150);
                do_send(8'h55);
            end
        join
        wait_for(SIG_BUSY, 1'b0, 4000, "busy_fall", ok);
        wait_ticks(60);
        check("busy_one_done", done_cnt, dc + 1);
        check("busy_no_refire", {31'd0, ckOe}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);

        check("leftover_results", exp_res.size(), 0);
        check("leftover_frames", exp_frames.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
